// File: rtl/rv_lsu.sv
// Load/store unit for the MEM stage: one outstanding access on a byte-lane memory port.
// Optional RV_LSU_TIMEOUT_EN aborts an access that waits MAX_WAIT cycles without mem_ack.
module rv_lsu #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_sign_ext,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    state_t r_state, w_state_next;

    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic              r_sign_ext;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [BE_W-1:0]   r_mem_be;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [XLEN-1:0]   r_resp_rdata;
    logic [4:0]        r_resp_rd;
    logic              r_resp_err;

    logic              w_misalign, w_req_err, w_req_mem, w_timeout, w_sign_bit;
    logic [OFF_W-1:0]  w_req_off;
    logic [BE_W-1:0]   w_size_be;
    logic [XLEN-1:0]   w_lane_rdata, w_load_data;
    logic [31:0]       w_nbits;

    assign w_req_off = req_addr[OFF_W-1:0];

    always_comb begin
        w_misalign = 1'b0;
        w_size_be  = '1;
        case (req_size)
            2'b00: begin w_misalign = |req_addr[1:0]; w_size_be = BE_W'(4'hF); end
            2'b01: begin w_misalign = req_addr[0];    w_size_be = BE_W'(2'h3); end
            2'b10: begin w_misalign = 1'b0;           w_size_be = BE_W'(1'b1); end
            default: begin w_misalign = |req_addr[2:0]; w_size_be = '1; end
        endcase
    end

    assign w_req_err = (req_read & req_write) | ((req_size == 2'b11) && (XLEN == 32)) | w_misalign;
    assign w_req_mem = ~w_req_err & (req_read | req_write);

    // Load path: move the addressed lane down to bit 0, then extend from the access's top bit.
    assign w_lane_rdata = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_nbits    = XLEN;
        w_sign_bit = w_lane_rdata[XLEN-1];
        case (r_size)
            2'b00: begin w_nbits = 32; w_sign_bit = w_lane_rdata[31]; end
            2'b01: begin w_nbits = 16; w_sign_bit = w_lane_rdata[15]; end
            2'b10: begin w_nbits = 8;  w_sign_bit = w_lane_rdata[7];  end
            default: begin w_nbits = XLEN; w_sign_bit = w_lane_rdata[XLEN-1]; end
        endcase
    end

    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
            assign w_load_data[gi] = (32'(gi) < w_nbits) ? w_lane_rdata[gi]
                                                         : (w_sign_bit & r_sign_ext);
        end
    endgenerate

`ifdef RV_LSU_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_state != S_ACCESS) begin
            r_wait_cnt <= '0;
        end else if (!mem_ack) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    assign w_timeout = (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));
`else
    logic w_unused_max_wait;
    assign w_unused_max_wait = (MAX_WAIT > 0);
    assign w_timeout         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_state_next = w_req_mem ? S_ACCESS : S_RESP;
            S_ACCESS: if (mem_ack || w_timeout) w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off        <= '0;
            r_size       <= '0;
            r_sign_ext   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_resp_rdata <= '0;
            r_resp_rd    <= '0;
            r_resp_err   <= 1'b0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_off        <= w_req_off;
            r_size       <= req_size;
            r_sign_ext   <= req_sign_ext;
            r_resp_rd    <= req_rd;
            r_resp_err   <= w_req_err;
            r_resp_rdata <= '0;
            // Memory-side fields only move for real accesses so the port stays quiet otherwise.
            if (w_req_mem) begin
                r_mem_we    <= req_write;
                r_mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_mem_be    <= w_size_be << w_req_off;
                r_mem_wdata <= req_wdata << {w_req_off, 3'b000};
            end
        end else if (r_state == S_ACCESS) begin
            if (mem_ack) begin
                r_resp_rdata <= r_mem_we ? '0 : w_load_data;
            end else if (w_timeout) begin
                r_resp_err <= 1'b1;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign mem_req    = (r_state == S_ACCESS);
    assign resp_valid = (r_state == S_RESP);
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_resp_rdata;
    assign resp_rd    = r_resp_rd;
    assign resp_err   = r_resp_err;
endmodule

// File: tb/tb_rv_lsu.sv
// Randomised bench for rv_lsu at XLEN=32 and XLEN=64 against a byte-arithmetic reference model.
module tb_rv_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] t_addr;
    logic [63:0] t_wdata, t_rdata;
    logic        t_read, t_write, t_sext;
    logic [1:0]  t_size;
    logic [4:0]  t_rd;
    logic        v32, v64, a32, a64;

    logic        r32_ready, r32_rvalid, r32_err, r32_busy, r32_mreq, r32_mwe;
    logic [31:0] r32_rdata, r32_maddr, r32_mwdata;
    logic [4:0]  r32_rd;
    logic [3:0]  r32_mbe;
    logic        r64_ready, r64_rvalid, r64_err, r64_busy, r64_mreq, r64_mwe;
    logic [63:0] r64_rdata, r64_mwdata;
    logic [31:0] r64_maddr;
    logic [4:0]  r64_rd;
    logic [7:0]  r64_mbe;

    rv_lsu #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(4)) u_d32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_ready(r32_ready), .req_addr(t_addr),
        .req_wdata(t_wdata[31:0]), .req_read(t_read), .req_write(t_write), .req_size(t_size),
        .req_sign_ext(t_sext), .req_rd(t_rd), .resp_valid(r32_rvalid), .resp_rdata(r32_rdata),
        .resp_rd(r32_rd), .resp_err(r32_err), .busy(r32_busy), .mem_req(r32_mreq),
        .mem_we(r32_mwe), .mem_addr(r32_maddr), .mem_be(r32_mbe), .mem_wdata(r32_mwdata),
        .mem_ack(a32), .mem_rdata(t_rdata[31:0])
    );

    rv_lsu #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(4)) u_d64 (
        .clk(clk), .rst(rst), .req_valid(v64), .req_ready(r64_ready), .req_addr(t_addr),
        .req_wdata(t_wdata), .req_read(t_read), .req_write(t_write), .req_size(t_size),
        .req_sign_ext(t_sext), .req_rd(t_rd), .resp_valid(r64_rvalid), .resp_rdata(r64_rdata),
        .resp_rd(r64_rd), .resp_err(r64_err), .busy(r64_busy), .mem_req(r64_mreq),
        .mem_we(r64_mwe), .mem_addr(r64_maddr), .mem_be(r64_mbe), .mem_wdata(r64_mwdata),
        .mem_ack(a64), .mem_rdata(t_rdata)
    );

    logic        sel64;
    logic        o_ready, o_rvalid, o_err, o_busy, o_mreq, o_mwe;
    logic [63:0] o_rdata, o_mwdata;
    logic [31:0] o_maddr;
    logic [7:0]  o_mbe;
    logic [4:0]  o_rd;

    always_comb begin
        o_ready  = sel64 ? r64_ready  : r32_ready;
        o_rvalid = sel64 ? r64_rvalid : r32_rvalid;
        o_err    = sel64 ? r64_err    : r32_err;
        o_busy   = sel64 ? r64_busy   : r32_busy;
        o_mreq   = sel64 ? r64_mreq   : r32_mreq;
        o_mwe    = sel64 ? r64_mwe    : r32_mwe;
        o_rdata  = sel64 ? r64_rdata  : {32'd0, r32_rdata};
        o_mwdata = sel64 ? r64_mwdata : {32'd0, r32_mwdata};
        o_maddr  = sel64 ? r64_maddr  : r32_maddr;
        o_mbe    = sel64 ? r64_mbe    : {4'd0, r32_mbe};
        o_rd     = sel64 ? r64_rd     : r32_rd;
    end

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: everything derived from byte counts and offsets with wide integer arithmetic.
    task automatic model(input bit is64, input logic [31:0] addr, input logic [1:0] size,
                         input bit rdo, input bit wro, input bit sx,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         output bit err, output bit noop, output logic [7:0] be,
                         output logic [31:0] maddr, output logic [63:0] mwdata,
                         output logic [63:0] ldata);
        int nb, xb, off;
        logic [127:0] xmask, smask, v;
        nb    = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 8;
        xb    = is64 ? 8 : 4;
        off   = int'(addr[2:0]) % xb;
        err   = (rdo && wro) || (size == 2'd3 && !is64) || ((int'(addr[2:0]) % nb) != 0);
        noop  = !err && !rdo && !wro;
        be    = 8'(((1 << nb) - 1) << off);
        maddr = addr - 32'(off);
        xmask = (128'd1 << (8 * xb)) - 128'd1;
        smask = (128'd1 << (8 * nb)) - 128'd1;
        mwdata = 64'(((128'(wdata) & xmask) << (8 * off)) & xmask);
        v = ((128'(rdata) & xmask) >> (8 * off)) & smask;
        if (sx && v[8 * nb - 1]) v = v | ~smask;
        ldata = wro ? 64'd0 : 64'(v & xmask);
    endtask

    task automatic txn(input bit is64, input logic [31:0] addr, input logic [63:0] wdata,
                       input bit rdo, input bit wro, input logic [1:0] size, input bit sx,
                       input logic [4:0] tag, input logic [63:0] rdata, input int waits);
        bit err, noop;
        logic [7:0] be;
        logic [31:0] maddr;
        logic [63:0] mwdata, ldata;
        model(is64, addr, size, rdo, wro, sx, wdata, rdata, err, noop, be, maddr, mwdata, ldata);
        sel64 = is64;
        #1;
        check("ready_idle", 64'(o_ready), 64'd1);
        t_addr = addr; t_wdata = wdata; t_read = rdo; t_write = wro;
        t_size = size; t_sext = sx; t_rd = tag;
        v32 = !is64; v64 = is64;
        @(negedge clk);
        v32 = 1'b0; v64 = 1'b0;
        t_addr = $urandom; t_wdata = {$urandom, $urandom}; t_rd = 5'($urandom);
        t_size = 2'($urandom); t_sext = 1'($urandom); t_read = 1'($urandom); t_write = 1'($urandom);
        #1;
        if (err || noop) begin
            check("short_mreq", 64'(o_mreq), 64'd0);
            check("short_rvalid", 64'(o_rvalid), 64'd1);
            check("short_err", 64'(o_err), 64'(err));
            check("short_rdata", o_rdata, 64'd0);
            check("short_rd", 64'(o_rd), 64'(tag));
            a32 = !is64; a64 = is64;
            @(negedge clk);
            a32 = 1'b0; a64 = 1'b0;
            #1;
            check("short_ready", 64'(o_ready), 64'd1);
            check("short_rvalid_off", 64'(o_rvalid), 64'd0);
            check("short_mreq_off", 64'(o_mreq), 64'd0);
        end else begin
            for (int w = 0; w <= waits; w++) begin
                check("acc_mreq", 64'(o_mreq), 64'd1);
                check("acc_busy", 64'(o_busy), 64'd1);
                check("acc_ready", 64'(o_ready), 64'd0);
                check("acc_rvalid", 64'(o_rvalid), 64'd0);
                check("acc_we", 64'(o_mwe), 64'(wro));
                check("acc_addr", 64'(o_maddr), 64'(maddr));
                check("acc_be", 64'(o_mbe), 64'(be));
                check("acc_wdata", o_mwdata, mwdata);
                t_rdata = (w == waits) ? rdata : {$urandom, $urandom};
                a32 = !is64 && (w == waits);
                a64 = is64 && (w == waits);
                @(negedge clk);
                #1;
            end
            a32 = 1'b0; a64 = 1'b0;
            t_rdata = {$urandom, $urandom};
            check("resp_rvalid", 64'(o_rvalid), 64'd1);
            check("resp_err", 64'(o_err), 64'd0);
            check("resp_rdata", o_rdata, ldata);
            check("resp_rd", 64'(o_rd), 64'(tag));
            check("resp_mreq", 64'(o_mreq), 64'd0);
            check("resp_ready", 64'(o_ready), 64'd0);
            @(negedge clk);
            #1;
            check("post_ready", 64'(o_ready), 64'd1);
            check("post_rvalid", 64'(o_rvalid), 64'd0);
        end
        $display("txn %0d xlen=%0d addr=0x%08h size=%0d rd=%0b wr=%0b sx=%0b waits=%0d err=%0b noop=%0b rdata=0x%0h",
                 txn_no, is64 ? 64 : 32, addr, size, rdo, wro, sx, waits, err, noop, ldata);
        txn_no++;
    endtask

    initial begin
        rst = 1'b1; v32 = 1'b0; v64 = 1'b0; a32 = 1'b0; a64 = 1'b0; sel64 = 1'b0;
        t_addr = '0; t_wdata = '0; t_rdata = '0; t_read = 1'b0; t_write = 1'b0;
        t_size = '0; t_sext = 1'b0; t_rd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            #1;
            check("rst_ready", 64'(o_ready), 64'd1);
            check("rst_busy", 64'(o_busy), 64'd0);
            check("rst_mreq", 64'(o_mreq), 64'd0);
            check("rst_rvalid", 64'(o_rvalid), 64'd0);
            check("rst_err", 64'(o_err), 64'd0);
            check("rst_mwe", 64'(o_mwe), 64'd0);
            check("rst_maddr", 64'(o_maddr), 64'd0);
            check("rst_mbe", 64'(o_mbe), 64'd0);
            check("rst_mwdata", o_mwdata, 64'd0);
            check("rst_rdata", o_rdata, 64'd0);
            check("rst_rd", 64'(o_rd), 64'd0);
        end

        // Directed cases from the access rules.
        txn(0, 32'h103, 64'hAB, 0, 1, 2'b10, 0, 5'd3, 64'd0, 0);
        txn(0, 32'h102, 64'd0, 1, 0, 2'b10, 1, 5'd7, 64'h0080_0000, 0);
        txn(0, 32'h102, 64'd0, 1, 0, 2'b10, 0, 5'd7, 64'h0080_0000, 0);
        txn(0, 32'h101, 64'd0, 1, 0, 2'b01, 1, 5'd9, 64'd0, 0);
        txn(0, 32'h100, 64'd0, 1, 1, 2'b00, 0, 5'd10, 64'd0, 0);
        txn(1, 32'h1004, 64'd0, 1, 0, 2'b00, 1, 5'd11, 64'h8000_0001_0000_0000, 0);
        txn(1, 32'h1004, 64'd0, 1, 0, 2'b11, 0, 5'd12, 64'd0, 0);
        txn(1, 32'h1008, 64'hDEAD_BEEF_0123_4567, 0, 1, 2'b11, 0, 5'd13, 64'd0, 1);
        txn(0, 32'h200, 64'd0, 1, 0, 2'b00, 0, 5'd14, 64'h1234_5678, 3);
        txn(0, 32'h204, 64'd0, 1, 0, 2'b11, 0, 5'd15, 64'd0, 0);
        txn(1, 32'h300, 64'd0, 0, 0, 2'b00, 0, 5'd16, 64'd0, 0);

        // Reset during the second ACCESS cycle abandons the access.
        sel64 = 1'b0;
        t_addr = 32'h400; t_read = 1'b1; t_write = 1'b0; t_size = 2'b00; t_sext = 1'b0; t_rd = 5'd17;
        v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
        #1;
        check("rstmid_mreq1", 64'(o_mreq), 64'd1);
        @(negedge clk);
        #1;
        check("rstmid_mreq2", 64'(o_mreq), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_mreq_off", 64'(o_mreq), 64'd0);
        check("rstmid_ready", 64'(o_ready), 64'd1);
        check("rstmid_busy", 64'(o_busy), 64'd0);
        check("rstmid_rvalid", 64'(o_rvalid), 64'd0);
        @(negedge clk);
        #1;
        check("rstmid_rvalid2", 64'(o_rvalid), 64'd0);
        $display("txn %0d xlen=32 reset during access", txn_no);
        txn_no++;

`ifdef RV_LSU_TIMEOUT_EN
        sel64 = 1'b1;
        t_addr = 32'h40; t_read = 1'b1; t_write = 1'b0; t_size = 2'b11; t_sext = 1'b0; t_rd = 5'd18;
        v64 = 1'b1;
        @(negedge clk);
        v64 = 1'b0;
        for (int w = 0; w < 4; w++) begin
            #1;
            check("tmo_mreq", 64'(o_mreq), 64'd1);
            @(negedge clk);
        end
        #1;
        check("tmo_mreq_off", 64'(o_mreq), 64'd0);
        check("tmo_rvalid", 64'(o_rvalid), 64'd1);
        check("tmo_err", 64'(o_err), 64'd1);
        check("tmo_rdata", o_rdata, 64'd0);
        a64 = 1'b1;
        @(negedge clk);
        a64 = 1'b0;
        #1;
        check("tmo_ready", 64'(o_ready), 64'd1);
        check("tmo_rvalid_off", 64'(o_rvalid), 64'd0);
        @(negedge clk);
        #1;
        check("tmo_late_ack", 64'(o_rvalid | o_mreq), 64'd0);
        $display("txn %0d xlen=64 timeout", txn_no);
        txn_no++;
`endif

        for (int n = 0; n < 150; n++) begin
            bit is64, rdo, wro;
            logic [1:0] size;
            logic [31:0] addr;
            int op, nb;
            is64 = 1'($urandom);
            size = 2'($urandom);
            nb   = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 8;
            addr = $urandom;
            if ($urandom_range(3) != 0) addr = addr & ~(32'(nb) - 32'd1);
            op  = $urandom_range(7);
            rdo = (op == 0) || (op >= 2 && op <= 4);
            wro = (op == 0) || (op >= 5);
            txn(is64, addr, {$urandom, $urandom}, rdo, wro, size, 1'($urandom), 5'($urandom),
                {$urandom, $urandom}, $urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Parametrised load/store unit for the MEM stage of the rv pipeline; generalises the existing WORD/HWORD/BYTE memory control to XLEN = 32 or 64, adding DWORD accesses.
- Accepts one request from EX/MEM and drives a byte-lane memory port with wait-state handshake.
- Aligns, masks and sign/zero-extends load data, and returns it with the destination register tag.
- Holds the pipeline busy while an access is outstanding.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- MAX_WAIT, 16, wait cycles before timeout; only used when RV_LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid is also high
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- req_read  in  1  load
- req_write  in  1  store
- req_size  in  2  00 WORD, 01 HWORD, 10 BYTE, 11 DWORD (DWORD legal only when XLEN=64)
- req_sign_ext  in  1  sign-extend load result
- req_rd  in  5  destination register tag
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_rd  out  5  tag of the completed request
- resp_err  out  1  misaligned, illegal or timed-out access
- busy  out  1  high whenever state is not IDLE
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  req_addr with the low log2(XLEN/8) bits cleared
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_ack  in  1  access complete; mem_rdata is valid in the same cycle
- mem_rdata  in  XLEN  read data

Behaviour:
- Reset: state IDLE; mem_req, mem_we, resp_valid, resp_err, busy = 0; mem_addr, mem_be, mem_wdata, resp_rdata, resp_rd = 0. A reset asserted mid-access abandons it; mem_req is low from the next edge and no response is issued.
- FSM states: IDLE, ACCESS, RESP. req_ready = (state == IDLE).
- IDLE accepts a request on req_valid && req_ready and latches all request fields.
  - Legal access: go to ACCESS with mem_req=1 on the next cycle.
  - Error: go straight to RESP with resp_err=1 and no mem_req. Errors are:
    - req_read && req_write together;
    - DWORD requested with XLEN=32;
    - misalignment (HWORD addr[0]!=0; WORD addr[1:0]!=0; DWORD addr[2:0]!=0).
  - Neither read nor write: RESP with resp_err=0 and rdata 0, no memory access.
- ACCESS: mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_ack is sampled high. mem_rdata is captured on the ack edge and the FSM goes to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency:
  - Zero-wait access (ack in the first ACCESS cycle): accept cycle 0, mem_req cycle 1, resp_valid cycle 2, req_ready high again cycle 3.
  - Each wait cycle adds one.
  - Error path: resp_valid in cycle 1.
- Lane rules, with off = addr[log2(XLEN/8)-1:0]:
  - mem_be = size mask (BYTE 1, HWORD 3, WORD 0xF, DWORD 0xFF) << off.
  - mem_wdata = req_wdata << (8*off).
  - Load: data = mem_rdata >> (8*off), truncated to the access size, then sign- or zero-extended to XLEN.
  - WORD on XLEN=64 extends bit 31.
- Stores report resp_rdata=0.
- mem_ack outside ACCESS is ignored.

Optional Feature:
RV_LSU_TIMEOUT_EN:
- Defined: a wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches MAX_WAIT, mem_req drops, the FSM goes to RESP with resp_err=1, and a late mem_ack is ignored.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- XLEN=32, SB addr 0x103, wdata 0xAB, ack immediate -> mem_addr 0x100, mem_be 4'b1000, mem_wdata 0xAB00_0000, mem_we=1, resp_valid in cycle 2, resp_rdata=0.
- LB addr 0x102, mem_rdata 0x0080_0000:
  - sign_ext=1 -> resp_rdata 0xFFFF_FF80;
  - sign_ext=0 -> 0x0000_0080;
  - resp_rd equals req_rd (e.g. 5'd7).
- LH addr 0x101 -> no mem_req, resp_valid and resp_err=1 in cycle 1, req_ready high in cycle 2; req_read=req_write=1 gives the same result.
- XLEN=64, LW signed addr 0x1004, mem_rdata 0x8000_0001_0000_0000 -> mem_be 8'hF0, resp_rdata 0xFFFF_FFFF_8000_0001; DWORD at 0x1004 -> resp_err=1.
- mem_ack delayed 3 cycles -> busy high and mem_* fields stable for 3 ACCESS cycles plus the ack cycle; a second req_valid is not accepted until the cycle after resp_valid.
- With RV_LSU_TIMEOUT_EN and MAX_WAIT=4, no ack -> mem_req drops after 4 cycles, resp_err=1, and a later ack is ignored. Separately, asserting rst in the second ACCESS cycle -> mem_req=0 from the next edge, no resp_valid, req_ready=1.
